alu_issue_unit: RTL

Sequential front-end for the 4-bit `alu`. It accepts operation commands over a valid/ready handshake and buffers them in a small command FIFO. It issues one command at a time to the combinational ALU, captures the 8-bit result in a register, and presents it downstream with its own valid/ready handshake. This decouples the ALU from bursty producers and stalling consumers.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_fifo.sv | 72 +++++++
 rtl/alu_issue_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU issue front-end: opcode constants,
//   FSM state encoding, the packed command layout and an opcode
//   legality helper.
//
//   Optional feature macro used by the units that import this package:
//   ALU_ISSUE_CHECK_EN (illegal-opcode flagging at result capture).
package alu_pkg;

   // Packed command width: op1 (4) + op2 (4) + ctrl (3)
   localparam int CMD_W = 11;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MULT = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   typedef struct packed {
      logic [3:0] op1;
      logic [3:0] op2;
      logic [2:0] ctrl;
   } cmd_t;

   // Opcodes above OP_NOR have no defined ALU function
   function automatic logic is_legal_op(input logic [2:0] ctrl);
      return (ctrl <= OP_NOR);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo
//   Synchronous command FIFO with registered read/write pointers.
//   Pointers carry one extra MSB so full and empty can be told apart
//   when the low bits match.
//
//   Ports:
//     i_clk, i_rst   clock, synchronous active-high reset (flushes)
//     i_push         write request, ignored while full
//     i_push_data    command word to write
//     i_pop          read request, ignored while empty
//     o_head         command at the read pointer (combinational)
//     o_full         no free entry
//     o_empty        no stored entry
//     o_count        occupancy, 0..DEPTH
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_W
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_en;
   logic             pop_en;

   // A push while full is dropped even if a pop frees a slot this cycle
   assign push_en = i_push && !o_full;
   assign pop_en  = i_pop && !o_empty;

   assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign o_empty = (wr_ptr == rd_ptr);
   assign o_count = wr_ptr - rd_ptr;
   assign o_head  = mem[rd_ptr[AW-1:0]];

   // Storage needs no reset: the pointers alone define what is valid
   always_ff @(posedge i_clk) begin
      if (push_en) begin
         mem[wr_ptr[AW-1:0]] <= i_push_data;
      end
   end

   // Pointer update; both may advance in the same cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Sequential front-end for the 4-bit combinational ALU. Commands are
//   buffered in alu_cmd_fifo, issued one at a time through registered
//   ALU operand/opcode outputs, and the ALU result is captured and held
//   behind a valid/ready handshake.
//
//   Optional feature: define ALU_ISSUE_CHECK_EN to flag opcodes 5-7 at
//   capture (o_res_err = 1, o_res_data = 0). Without it o_res_err is 0
//   and o_res_data is always the raw ALU result.
//
//   Ports:
//     i_clk, i_rst               clock, synchronous active-high reset
//     i_cmd_valid / o_cmd_ready  command handshake
//     i_op1, i_op2, i_ctrl       command operands and opcode
//     o_alu_op1/op2/ctrl         registered drive to the ALU
//     i_alu_data                 ALU result (combinational from o_alu_*)
//     o_res_valid / i_res_ready  result handshake
//     o_res_data, o_res_ctrl     captured result and its opcode
//     o_res_err                  result came from an illegal opcode
//     o_count                    FIFO occupancy
module alu_issue_unit
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  logic [3:0]               i_op1,
   input  logic [3:0]               i_op2,
   input  logic [2:0]               i_ctrl,
   output logic [3:0]               o_alu_op1,
   output logic [3:0]               o_alu_op2,
   output logic [2:0]               o_alu_ctrl,
   input  logic [7:0]               i_alu_data,
   output logic                     o_res_valid,
   input  logic                     i_res_ready,
   output logic [7:0]               o_res_data,
   output logic [2:0]               o_res_ctrl,
   output logic                     o_res_err,
   output logic [$clog2(DEPTH):0]   o_count
);

   logic [1:0] state;
   cmd_t       in_cmd;
   cmd_t       head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;
   logic [7:0] capture_data;

   assign in_cmd = '{op1: i_op1, op2: i_op2, ctrl: i_ctrl};
   assign o_cmd_ready = !fifo_full;

   // Pop from IDLE, or straight out of HOLD when the consumer takes the
   // current result, so a busy stream yields one result every 2 cycles
   assign pop = !fifo_empty &&
                ((state == ST_IDLE) || ((state == ST_HOLD) && i_res_ready));

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (i_cmd_valid),
      .i_push_data (in_cmd),
      .i_pop       (pop),
      .o_head      (head),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_count     (o_count)
   );

`ifdef ALU_ISSUE_CHECK_EN
   logic res_err;

   assign capture_data = is_legal_op(o_alu_ctrl) ? i_alu_data : 8'h00;
   assign o_res_err    = res_err;

   // The error flag travels with the result it describes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         res_err <= 1'b0;
      end else if (state == ST_EXEC) begin
         res_err <= !is_legal_op(o_alu_ctrl);
      end
   end
`else
   assign capture_data = i_alu_data;
   assign o_res_err    = 1'b0;
`endif

   // Issue FSM: ALU drive registers change only on pop edges, the result
   // register only at the end of EXEC
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         o_alu_op1   <= '0;
         o_alu_op2   <= '0;
         o_alu_ctrl  <= '0;
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_ctrl  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  o_alu_op1  <= head.op1;
                  o_alu_op2  <= head.op2;
                  o_alu_ctrl <= head.ctrl;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               o_res_data  <= capture_data;
               o_res_ctrl  <= o_alu_ctrl;
               o_res_valid <= 1'b1;
               state       <= ST_HOLD;
            end
            ST_HOLD: begin
               if (i_res_ready) begin
                  o_res_valid <= 1'b0;
                  if (pop) begin
                     o_alu_op1  <= head.op1;
                     o_alu_op2  <= head.op2;
                     o_alu_ctrl <= head.ctrl;
                     state      <= ST_EXEC;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
